// File: rtl/multdiv_booth_mult.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_booth_mult
//  Description : Sequential radix-2 Booth multiplier, one Booth step per clock.
//                Each step adds the multiplicand (true, or inverted with
//                carry-in) to the partial-product accumulator. It then
//                arithmetic-shifts {ACC, Q, q_m1} right by one bit. After
//                DATA_WIDTH steps it presents the low DATA_WIDTH bits of the
//                signed product and an overflow flag, with a one-cycle ready
//                pulse.
//  Ports       : clock          - rising-edge clock
//                reset          - synchronous active-high reset
//                ctrl_MULT      - start pulse (restarts if already running)
//                data_operandA  - multiplicand M, latched on start
//                data_operandB  - multiplier Q, latched on start
//                data_result    - low DATA_WIDTH bits of A*B (held)
//                data_exception - product does not fit in DATA_WIDTH (held)
//                data_resultRDY - one-cycle result-valid pulse
//                busy           - multiply in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_booth_mult #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ctrl_MULT,
    input  logic [DATA_WIDTH-1:0] data_operandA,
    input  logic [DATA_WIDTH-1:0] data_operandB,
    output logic [DATA_WIDTH-1:0] data_result,
    output logic                  data_exception,
    output logic                  data_resultRDY,
    output logic                  busy
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] c_cnt_last = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_m;
    logic [2*W:0]    r_p;      // {ACC, Q, q_m1}
    logic [CW-1:0]   r_cnt;

    logic [W-1:0]    w_acc;
    logic [1:0]      w_pair;
    logic            w_sub;
    logic            w_active;
    logic [W-1:0]    w_addend;
    logic [W-1:0]    w_cin;
    logic [W-1:0]    w_sum;
    logic            w_ovf;
    logic [W-1:0]    w_new_acc;
    logic            w_msb_in;
    logic [2*W:0]    w_p_next;
    logic [W-1:0]    w_hi;
    logic            w_exc;

    // Adder datapath and Booth recoding for the current step.
    always_comb begin
        w_acc    = r_p[2*W:W+1];
        w_pair   = r_p[1:0];                 // {Q[0], q_m1}
        w_sub    = (w_pair == 2'b10);
        w_active = w_pair[1] ^ w_pair[0];
        w_addend = w_sub ? ~r_m : r_m;
        w_cin    = {{(W-1){1'b0}}, w_sub};
        w_sum    = w_acc + w_addend + w_cin;
        // Signed overflow of the W-bit add: same-sign inputs, sign flip out.
        w_ovf    = (w_acc[W-1] == w_addend[W-1]) && (w_sum[W-1] != w_acc[W-1]);
        w_new_acc = w_active ? w_sum : w_acc;
        // The true (W+1)-bit sign of ACC+M is sum[MSB]^ovf. Shifting it in
        // keeps the 2W-bit product exact even for M = -2^(W-1).
        w_msb_in = w_active ? (w_sum[W-1] ^ w_ovf) : w_acc[W-1];
        w_p_next = {w_msb_in, w_new_acc, r_p[W:1]};
        // Product fits in W bits only if the upper half is a sign extension.
        w_hi     = r_p[2*W:W+1];
        w_exc    = (w_hi != {W{r_p[W]}});
    end

    // Later assignments override earlier ones. A start therefore wins over
    // RUN/DONE transitions, while DONE still publishes its outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_m            <= '0;
            r_p            <= '0;
            r_cnt          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;

            if (r_state == S_DONE) begin
                data_result    <= r_p[W:1];
                data_exception <= w_exc;
                data_resultRDY <= 1'b1;
                busy           <= 1'b0;
                r_state        <= S_IDLE;
            end

            if (r_state == S_RUN) begin
                r_p   <= w_p_next;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == c_cnt_last) begin
                    r_state <= S_DONE;
                end
            end

            if (ctrl_MULT) begin
                r_m     <= data_operandA;
                r_p     <= {{W{1'b0}}, data_operandB, 1'b0};
                r_cnt   <= '0;
                r_state <= S_RUN;
                busy    <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
